mem_access_unit: RTL and testbench

//  Parametrised load/store unit between the register/stack datapath and a local data RAM.

---
 rtl/mem_access_unit.sv | 128 ++++++++++++
 tb/tb_mem_access_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: one-at-a-time load/store front end to a local data RAM.
// Define MEM_BOUNDS_CHK_EN to reject addresses >= DEPTH instead of wrapping them.
module mem_access_unit #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DEPTH      = 1024,
  parameter int RD_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        addr_sel,
  input  logic [1:0]        data_sel,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] sp_in,
  input  logic [DATA_W-1:0] ze_imm,
  input  logic [DATA_W-1:0] ls_imm,
  input  logic [DATA_W-1:0] MaryData,
  input  logic [DATA_W-1:0] ShelleyData,
  input  logic [DATA_W-1:0] RAData,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] LAT_M1 = 4'(RD_LATENCY - 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  idx_q;
  logic              oob_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              oob;

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign idx       = addr[IDX_W-1:0];

  always_comb begin
    addr = '0;
    unique case (addr_sel)
      3'b000:  addr = pc;
      3'b001:  addr = ADDR_W'(ze_imm);
      3'b010:  addr = ADDR_W'(MaryData);
      3'b011:  addr = ADDR_W'(ShelleyData);
      3'b100:  addr = sp_in + ADDR_W'(1);
      3'b101:  addr = sp_in + ADDR_W'(ls_imm);
      3'b110:  addr = sp_in;
      default: addr = '0;
    endcase
  end

  always_comb begin
    wdata = '0;
    unique case (data_sel)
      2'b00:   wdata = MaryData;
      2'b01:   wdata = ShelleyData;
      2'b10:   wdata = RAData;
      default: wdata = ze_imm;
    endcase
  end

`ifdef MEM_BOUNDS_CHK_EN
  assign oob = 32'(addr) >= 32'(DEPTH);
`else
  // Upper address bits are dropped: the RAM index wraps modulo DEPTH.
  logic unused_hi;
  assign oob       = 1'b0;
  assign unused_hi = ^addr[ADDR_W-1:IDX_W];
`endif

  // Stores commit on the accept edge, so a later load always sees them.
  always_ff @(posedge clock) begin
    if (accept && req_write && !oob)
      mem[idx] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      oob_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            idx_q <= idx;
            oob_q <= oob;
            if (req_write) begin
              rsp_valid <= 1'b1;
              rsp_data  <= wdata;
              rsp_err   <= oob;
            end else begin
              state <= RD_WAIT;
              cnt   <= LAT_M1;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == '0) begin
            state     <= IDLE;
            rsp_valid <= 1'b1;
            rsp_data  <= oob_q ? '0 : mem[idx_q];
            rsp_err   <= oob_q;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and random load/store traffic
// checked against an array-based memory model.
module tb_mem_access_unit;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;
`ifdef MEM_BOUNDS_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  addr_sel = '0;
  logic [1:0]  data_sel = '0;
  logic [15:0] pc = '0, sp_in = '0, ze_imm = '0, ls_imm = '0;
  logic [15:0] MaryData = '0, ShelleyData = '0, RAData = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data;
  logic        rsp_err;

  logic [15:0] mm [DEPTH];
  bit          kn [DEPTH];
  int          n_cmp = 0;
  int          n_bad = 0;

  mem_access_unit dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .addr_sel(addr_sel),
    .data_sel(data_sel), .pc(pc), .sp_in(sp_in),
    .ze_imm(ze_imm), .ls_imm(ls_imm),
    .MaryData(MaryData), .ShelleyData(ShelleyData),
    .RAData(RAData), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic int model_addr(input logic [2:0] as);
    case (as)
      3'd0:    return int'(pc);
      3'd1:    return int'(ze_imm);
      3'd2:    return int'(MaryData);
      3'd3:    return int'(ShelleyData);
      3'd4:    return (int'(sp_in) + 1) % 65536;
      3'd5:    return (int'(sp_in) + int'(ls_imm)) % 65536;
      3'd6:    return int'(sp_in);
      default: return 0;
    endcase
  endfunction

  function automatic logic [15:0] model_data(input logic [1:0] ds);
    case (ds)
      2'd0:    return MaryData;
      2'd1:    return ShelleyData;
      2'd2:    return RAData;
      default: return ze_imm;
    endcase
  endfunction

  // Expected load result for the current inputs; known=0 if never written.
  task automatic model_load(input logic [2:0] as, output logic [15:0] d,
                            output logic e, output bit known);
    int a;
    a = model_addr(as);
    e = CHK && a >= DEPTH;
    d = e ? 16'h0 : mm[a % DEPTH];
    known = e || kn[a % DEPTH];
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic op(input logic wr, input logic [2:0] as,
                    input logic [1:0] ds);
    int a, n;
    logic [15:0] ed;
    logic ee;
    bit known;
    a = model_addr(as);
    if (wr) begin
      ed = model_data(ds);
      ee = CHK && a >= DEPTH;
      known = 1'b1;
      if (!ee) begin
        mm[a % DEPTH] = ed;
        kn[a % DEPTH] = 1'b1;
      end
    end else begin
      model_load(as, ed, ee, known);
    end
    chk("ready_idle", req_ready, 1);
    req_write = wr; addr_sel = as; data_sel = ds;
    req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    wait_rsp(n);
    chk(wr ? "st_latency" : "ld_latency", n, wr ? 0 : LAT);
    chk("rsp_valid", rsp_valid, 1);
    if (known) chk(wr ? "st_data" : "ld_data", rsp_data, ed);
    chk("rsp_err", rsp_err, ee);
    @(posedge clock); #1;
    chk("pulse", rsp_valid, 0);
    if (known) chk("hold", rsp_data, ed);
  endtask

  task automatic rand_src();
    pc     = 16'($urandom_range(0, 63));
    ze_imm = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(1000, 1100))
                                         : 16'($urandom_range(0, 63));
    MaryData    = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                              : 16'($urandom_range(0, 63));
    ShelleyData = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                              : 16'($urandom_range(0, 63));
    RAData = 16'($urandom);
    sp_in  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(16'hFFF0, 16'hFFFF))
                                         : 16'($urandom_range(0, 48));
    ls_imm = 16'($urandom_range(0, 15));
  endtask

  initial begin
    logic [15:0] d1, d2;
    logic e1, e2;
    bit k1, k2;
    int n, seen;

    for (int i = 0; i < DEPTH; i++) kn[i] = 1'b0;

    #1;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_err", rsp_err, 0);
    #11 reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 64; i++) begin
      ze_imm = 16'(i); MaryData = 16'($urandom);
      op(1'b1, 3'b001, 2'b00);
    end

    MaryData = 16'hBEEF; ze_imm = 16'd5;
    op(1'b1, 3'b001, 2'b00);
    op(1'b0, 3'b001, 2'b00);
    chk("beef", rsp_data, 16'hBEEF);

    sp_in = 16'hFFFF; RAData = 16'h1234;
    op(1'b1, 3'b100, 2'b10);
    op(1'b0, 3'b111, 2'b00);
    chk("wrap_1234", rsp_data, 16'h1234);

    // Two held loads: second accepted in the first response cycle.
    ze_imm = 16'd7;
    model_load(3'b001, d1, e1, k1);
    addr_sel = 3'b001; req_write = 1'b0; req_valid = 1'b1;
    @(posedge clock); #1;
    chk("b2b_busy", req_ready, 0);
    ze_imm = 16'd9;
    model_load(3'b001, d2, e2, k2);
    wait_rsp(n);
    chk("b2b_lat1", n, LAT);
    chk("b2b_data1", rsp_data, d1);
    chk("b2b_ready_in_rsp", req_ready, 1);
    @(posedge clock); #1;
    req_valid = 1'b0;
    chk("b2b_accepted", req_ready, 0);
    wait_rsp(n);
    chk("b2b_lat2", n, LAT);
    chk("b2b_data2", rsp_data, d2);
    @(posedge clock); #1;

    // Reset one cycle into a load aborts it.
    ze_imm = 16'd5; addr_sel = 3'b001; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    @(posedge clock); #3;
    reset = 1'b1;
    #1;
    chk("arst_ready", req_ready, 1);
    chk("arst_valid", rsp_valid, 0);
    chk("arst_data", rsp_data, 0);
    chk("arst_err", rsp_err, 0);
    #3 reset = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(posedge clock); #1;
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", seen, 0);
    op(1'b0, 3'b001, 2'b00);
    chk("after_rst_beef", rsp_data, 16'hBEEF);

    ze_imm = 16'd1024; ShelleyData = 16'h5A5A;
    op(1'b1, 3'b001, 2'b01);
    op(1'b0, 3'b001, 2'b01);
    op(1'b0, 3'b111, 2'b00);
    chk("bound_addr0", rsp_data, CHK ? 16'h1234 : 16'h5A5A);

    for (int i = 0; i < 250; i++) begin
      rand_src();
      op(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
         2'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
